// File: rtl/gcd_rr_arbiter.sv
// ----------------------------------------------------------------------------
// gcd_rr_arbiter
//   Shares a single GCD unit between NREQ requesters. Requests are granted
//   round-robin with at most one transaction outstanding. The winner's request
//   goes to the GCD istream, and the GCD ostream result is routed back only to
//   the requester that owns the transaction. No message data is stored here:
//   result backpressure is left to the GCD unit, which holds its output.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   req_val/rdy/msg  per-requester request streams (msg i at [32*i+31:32*i])
//   resp_val/rdy     per-requester response handshake
//   resp_msg         shared 16-bit response data (0 when no response valid)
//   gcd_istream_*    request stream to the GCD unit
//   gcd_ostream_*    result stream from the GCD unit
//   busy             a transaction is in flight
//   owner            id of the current or last granted requester
//   txn_count        completed transactions, wraps at 2^16
// ----------------------------------------------------------------------------
module gcd_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_val,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [32*NREQ-1:0]    req_msg,
    output logic [NREQ-1:0]       resp_val,
    input  logic [NREQ-1:0]       resp_rdy,
    output logic [15:0]           resp_msg,
    output logic                  gcd_istream_val,
    input  logic                  gcd_istream_rdy,
    output logic [31:0]           gcd_istream_msg,
    input  logic                  gcd_ostream_val,
    output logic                  gcd_ostream_rdy,
    input  logic [15:0]           gcd_ostream_msg,
    output logic                  busy,
    output logic [IDW-1:0]        owner,
    output logic [15:0]           txn_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [15:0]    txn_q, txn_d;

    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [31:0]    win_msg;
    logic [IDW:0]   cand;
    logic           own_rdy;

    // Round-robin search starting at rr_ptr. The candidate id is kept one bit
    // wider so the modulo wrap is a single compare-and-subtract.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!win_found && req_val[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    // Winner message mux and owner's response-ready select.
    always_comb begin
        win_msg = '0;
        own_rdy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_found && win_id == IDW'(i))
                win_msg = req_msg[32*i +: 32];
            if (owner_q == IDW'(i))
                own_rdy = resp_rdy[i];
        end
    end

    // Next state and outputs. Outputs are additionally qualified by reset so
    // that asserting it forces every stream output low immediately, even
    // though IDLE would otherwise reflect req_val combinationally.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        owner_d         = owner_q;
        txn_d           = txn_q;
        req_rdy         = '0;
        resp_val        = '0;
        resp_msg        = '0;
        gcd_istream_val = 1'b0;
        gcd_istream_msg = '0;
        gcd_ostream_rdy = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    gcd_istream_val = win_found;
                    gcd_istream_msg = win_msg;
                    for (int i = 0; i < NREQ; i++)
                        req_rdy[i] = win_found && (win_id == IDW'(i)) && gcd_istream_rdy;
                    if (win_found && gcd_istream_rdy) begin
                        owner_d  = win_id;
                        rr_ptr_d = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < NREQ; i++)
                        resp_val[i] = gcd_ostream_val && (owner_q == IDW'(i));
                    resp_msg        = gcd_ostream_val ? gcd_ostream_msg : 16'h0;
                    gcd_ostream_rdy = own_rdy;
                    if (gcd_ostream_val && own_rdy) begin
                        txn_d   = txn_q + 16'd1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            txn_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            txn_q    <= txn_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign owner     = owner_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
module tb_gcd_rr_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_val, req_rdy, resp_val, resp_rdy;
  logic [32*NREQ-1:0] req_msg;
  logic [15:0]       resp_msg;
  logic              gcd_istream_val, gcd_istream_rdy;
  logic [31:0]       gcd_istream_msg;
  logic              gcd_ostream_val, gcd_ostream_rdy;
  logic [15:0]       gcd_ostream_msg;
  logic              busy;
  logic [1:0]        owner;
  logic [15:0]       txn_count;

  always #5 clk = ~clk;

  gcd_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .gcd_istream_val(gcd_istream_val), .gcd_istream_rdy(gcd_istream_rdy),
    .gcd_istream_msg(gcd_istream_msg),
    .gcd_ostream_val(gcd_ostream_val), .gcd_ostream_rdy(gcd_ostream_rdy),
    .gcd_ostream_msg(gcd_ostream_msg),
    .busy(busy), .owner(owner), .txn_count(txn_count)
  );

  // Stand-in GCD unit: fixed latency, holds its result until accepted.
  logic        g_busy;
  logic [1:0]  g_cnt;
  logic [15:0] g_res;

  function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_busy <= 1'b0; g_cnt <= '0; g_res <= '0; gcd_ostream_val <= 1'b0;
    end else if (!g_busy) begin
      if (gcd_istream_val) begin
        g_busy <= 1'b1; g_cnt <= 2'(LAT);
        g_res  <= gcd16(gcd_istream_msg[31:16], gcd_istream_msg[15:0]);
      end
    end else if (!gcd_ostream_val) begin
      if (g_cnt == 0) gcd_ostream_val <= 1'b1;
      else g_cnt <= g_cnt - 1'b1;
    end else if (gcd_ostream_rdy) begin
      gcd_ostream_val <= 1'b0; g_busy <= 1'b0;
    end
  end
  assign gcd_istream_rdy = !g_busy;
  assign gcd_ostream_msg = gcd_ostream_val ? g_res : 16'hDEAD;

  typedef struct {
    logic [3:0]   val;
    logic [3:0]   rrdy;
    logic [127:0] msg;
    int           id;
    logic [15:0]  res;
  } vec_t;

  vec_t        tbl[12];
  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] exp_txn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Entered just after a negedge; returns just after the negedge following
  // the response handshake (state IDLE again).
  task automatic apply(input vec_t v);
    int n;
    req_val = v.val; resp_rdy = v.rrdy; req_msg = v.msg; #1;
    n = 0;
    while (!(gcd_istream_val && gcd_istream_rdy) && n < 20) begin @(negedge clk); #1; n++; end
    chk("grant_wait", n, 0);
    chk("req_rdy", 32'(req_rdy), 32'(1) << v.id);
    chk("istream_msg", gcd_istream_msg, v.msg[32*v.id +: 32]);
    @(negedge clk); #1;
    chk("busy", 32'(busy), 1);
    chk("owner", 32'(owner), v.id);
    chk("req_rdy_busy", 32'(req_rdy), 0);
    chk("resp_msg_idle", 32'(resp_msg), 0);
    n = 0;
    while (resp_val == '0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("resp_val", 32'(resp_val), 32'(1) << v.id);
    chk("resp_msg", 32'(resp_msg), 32'(v.res));
    @(negedge clk); #1;
    exp_txn = exp_txn + 16'd1;
    chk("done_busy", 32'(busy), 0);
    chk("txn_count", 32'(txn_count), 32'(exp_txn));
  endtask

  logic [127:0] rr, m01, m02, m03, m04;

  initial begin
    rr  = {16'd5, 16'd2, 16'd4, 16'd2, 16'd3, 16'd2, 16'd2, 16'd2};
    m01 = {32'd0, 32'd0, 16'd15, 16'd5, 32'd0};
    m02 = {32'd0, 16'd12, 16'd8, 64'd0};
    m03 = {16'd35, 16'd21, 64'd0, 16'd9, 16'd6};
    m04 = {16'd35, 16'd21, 64'd0, 16'd21, 16'd14};
    tbl[0]  = '{4'b1111, 4'b1111, rr,  0, 16'd2};
    tbl[1]  = '{4'b1111, 4'b1111, rr,  1, 16'd1};
    tbl[2]  = '{4'b1111, 4'b1111, rr,  2, 16'd2};
    tbl[3]  = '{4'b1111, 4'b1111, rr,  3, 16'd1};
    tbl[4]  = '{4'b1111, 4'b1111, rr,  0, 16'd2};
    tbl[5]  = '{4'b0100, 4'b1111, m02, 2, 16'd4};
    tbl[6]  = '{4'b0010, 4'b0010, m01, 1, 16'd5};
    tbl[7]  = '{4'b1001, 4'b1111, m03, 3, 16'd7};
    tbl[8]  = '{4'b1001, 4'b1111, m03, 0, 16'd3};
    tbl[9]  = '{4'b1001, 4'b1111, m04, 0, 16'd7};
    tbl[10] = '{4'b1001, 4'b1111, m04, 3, 16'd7};
    tbl[11] = '{4'b0001, 4'b1111, m04, 0, 16'd7};

    // Reset with requests pending: everything must stay quiet.
    reset = 1'b0; req_val = 4'b1111; resp_rdy = 4'b1111; req_msg = rr;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_txn", 32'(txn_count), 0);
    chk("rst_req_rdy", 32'(req_rdy), 0);
    chk("rst_ival", 32'(gcd_istream_val), 0);
    chk("rst_imsg", gcd_istream_msg, 0);
    chk("rst_resp_val", 32'(resp_val), 0);
    chk("rst_ordy", 32'(gcd_ostream_rdy), 0);
    chk("rst_resp_msg", 32'(resp_msg), 0);
    reset = 1'b1; req_val = '0; exp_txn = '0; #1;
    chk("idle_ival", 32'(gcd_istream_val), 0);
    chk("idle_imsg", gcd_istream_msg, 0);

    // Round-robin, single requesters, pointer skip.
    for (int i = 0; i <= 8; i++) apply(tbl[i]);
    req_val = '0;

    // Response backpressure on owner 2 (rr_ptr=1); others' resp_rdy ignored.
    req_val = 4'b0100; req_msg = m02; resp_rdy = 4'b1011; #1;
    chk("bp_grant", 32'(req_rdy), 32'b0100);
    @(negedge clk); #1;
    req_val = 4'b1111;
    for (int n = 0; n < 20 && resp_val == '0; n++) begin @(negedge clk); #1; end
    for (int c = 0; c < 3; c++) begin
      chk("bp_resp_val", 32'(resp_val), 32'b0100);
      chk("bp_ordy", 32'(gcd_ostream_rdy), 0);
      chk("bp_no_grant", 32'(req_rdy), 0);
      chk("bp_msg", 32'(resp_msg), 16'd4);
      @(negedge clk); #1;
    end
    resp_rdy = 4'b1111; req_val = '0; #1;
    chk("bp_ordy_4th", 32'(gcd_ostream_rdy), 1);
    @(negedge clk); #1;
    exp_txn = exp_txn + 16'd1;
    chk("bp_idle", 32'(busy), 0);
    chk("bp_txn", 32'(txn_count), 32'(exp_txn));

    // Async reset mid-transaction (req 1 granted, pointer would move to 2).
    req_val = 4'b0010; req_msg = m01; #1;
    chk("ar_grant", 32'(req_rdy), 32'b0010);
    @(negedge clk); #1;
    chk("ar_busy", 32'(busy), 1);
    req_val = '0; #1;
    reset = 1'b0; #1;
    chk("ar_busy0", 32'(busy), 0);
    chk("ar_owner0", 32'(owner), 0);
    chk("ar_txn0", 32'(txn_count), 0);
    chk("ar_resp_val0", 32'(resp_val), 0);
    chk("ar_ordy0", 32'(gcd_ostream_rdy), 0);
    @(negedge clk); #1;
    reset = 1'b1; exp_txn = '0;
    for (int i = 9; i <= 10; i++) apply(tbl[i]);
    req_val = '0;

    // Counter wrap.
    force dut.txn_q = 16'hFFFF;
    @(negedge clk); #1;
    release dut.txn_q;
    #1;
    chk("wrap_pre", 32'(txn_count), 32'hFFFF);
    exp_txn = 16'hFFFF;
    apply(tbl[11]);
    req_val = '0;
    chk("wrap_zero", 32'(txn_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/gcd_rr_arbiter.md
Name: gcd_rr_arbiter

Overview:
- Shares one GCD unit (32-bit request {a[31:16], b[15:0]}, 16-bit response, val/rdy streams) between NREQ requesters.
- Grants requesters round-robin, with at most one transaction in flight.
- Forwards the winner's request to the unit and routes the unit's response back to that requester only.
- Sits between the requester ports and the GCD unit's istream/ostream.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of owner/pointer fields (derived; not overridable).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_val  in  NREQ  per-requester request valid.
- req_rdy  out  NREQ  per-requester request ready.
- req_msg  in  32*NREQ  requester i message at bits [32*i+31:32*i].
- resp_val  out  NREQ  per-requester response valid.
- resp_rdy  in  NREQ  per-requester response ready.
- resp_msg  out  16  shared response data; valid for the requester whose resp_val is set.
- gcd_istream_val  out  1  request valid to GCD unit.
- gcd_istream_rdy  in  1  GCD unit ready.
- gcd_istream_msg  out  32  request to GCD unit.
- gcd_ostream_val  in  1  GCD result valid.
- gcd_ostream_rdy  out  1  result ready to GCD unit.
- gcd_ostream_msg  in  16  GCD result.
- busy  out  1  a transaction is in flight (state BUSY).
- owner  out  IDW  id of the current or last granted requester.
- txn_count  out  16  completed transactions, wrapping.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, owner=0, txn_count=0. All req_rdy, resp_val, gcd_istream_val and gcd_ostream_rdy are 0; resp_msg=0; gcd_istream_msg=0.
- Reset asserted mid-transaction aborts it. Nothing is replayed. The GCD unit is reset by the same signal.
- FSM, 2 states:
  - IDLE: winner = first i with req_val[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NREQ.
    - gcd_istream_val = |req_val; gcd_istream_msg = req_msg[winner] (0 if none).
    - req_rdy[winner] = gcd_istream_rdy; all other req_rdy = 0.
    - Winner selection is combinational in the same cycle: 0-cycle arbitration latency.
    - On handshake (gcd_istream_val & gcd_istream_rdy): owner <= winner, rr_ptr <= (winner+1) mod NREQ, state <= BUSY.
    - No handshake: rr_ptr unchanged; winner may change next cycle if req_val changes (request valid need not be held stable by requesters).
  - BUSY: all req_rdy = 0; gcd_istream_val = 0.
    - resp_val[owner] = gcd_ostream_val; all other resp_val = 0.
    - resp_msg = gcd_ostream_msg when gcd_ostream_val=1, else 0.
    - gcd_ostream_rdy = resp_rdy[owner]; resp_rdy of other requesters is ignored.
    - On handshake (gcd_ostream_val & resp_rdy[owner]): txn_count <= txn_count+1 (mod 2^16), state <= IDLE.
- Arbitration gap: a new request can be accepted no earlier than the cycle after the response handshake, so back-to-back throughput is bounded by GCD latency + 1 cycle.
- busy=1 exactly in BUSY.
- Fairness: a continuously-valid requester is granted within NREQ grants.
- Single requester active: it is granted on every IDLE cycle in which it is valid, regardless of rr_ptr.
- Response backpressure: result held in GCD unit; the arbiter stores no data (no internal message registers).
- rr_ptr wrap: NREQ-1 wraps to 0; for non-power-of-2 NREQ, ids >= NREQ are never produced.
- gcd_ostream_val arriving in IDLE (should not occur): ignored; gcd_ostream_rdy=0 in IDLE.

Test Plan:
- Single requester: req 1 sends {15,5}. Required response: req_rdy[1] high in the same cycle, busy=1 next cycle, resp_val[1]=1 with resp_msg=0x0005, other resp_val=0, txn_count=1 after handshake.
- Round-robin: all 4 requesters hold valid with messages {i+2, 2}, resp_rdy all 1. Required response: grant order 0,1,2,3,0, responses 2,1,2,1, owner sequence matches the grant order.
- Pointer skip: rr_ptr=2, only req 0 and req 3 valid. Required response: req 3 granted, then req 0.
- Response backpressure: owner=2, resp_rdy[2]=0 for 3 cycles while gcd_ostream_val=1. Required response: gcd_ostream_rdy=0 and resp_val[2]=1 are held, with no new grant; the handshake occurs on the 4th cycle.
- Async reset mid-op: reset dropped between clock edges while in BUSY. Required response: all outputs go to reset values immediately, without waiting for a clock edge. After release, req 0 {21,14} is granted first and the result is 7.
- Counter wrap: preload via 65536 transactions, or force txn_count=0xFFFF, then complete one transaction. Required response: txn_count=0x0000.
